sfp_sum_xchg_ctrl: RTL and testbench
====================================

// Module: sfp_sum_xchg_ctrl
// PURPOSE
//   Row sequencer and partial-sum exchanger for a pair of sfp_row cores.
//   Per row: drives acc, then fifo_ext_rd to pop each core's partial L1 sum, and captures both sums.
//   Cross-couples the sums (sum_in0 <= sum_out1, sum_in1 <= sum_out0), then drives the two-cycle div.
//   Presents an out_valid/out_ready handshake when both sfp_out buses hold the normalised row.
//   Sits between the normalisation top and the two sfp_row instances; replaces bench-driven sequencing.
// PARAMETERS
//   bw       8           activation bit width (matches sfp_row)
//   bw_psum  2*bw+4      psum width; exchanged sum width is SW = bw_psum+4
//   ROW_W    4           width of nrows / row_idx
// PORTS
//   clk           in   1         clock
//   reset         in   1         synchronous, active-high
//   start         in   1         pulse: begin burst of nrows rows (ignored while busy)
//   nrows         in   ROW_W     rows in burst, sampled when start is accepted
//   busy          out  1         FSM not in IDLE
//   done          out  1         1-cycle pulse after last row handshake
//   row_idx       out  ROW_W     current row, 0-based
//   acc           out  1         to both cores
//   div           out  1         to both cores
//   fifo_ext_rd0  out  1         to core0
//   fifo_ext_rd1  out  1         to core1
//   sum_out0      in   SW        core0 partial sum (valid combinationally in RD cycle)
//   sum_out1      in   SW        core1 partial sum
//   sum_in0       out  SW        to core0 = captured sum_out1
//   sum_in1       out  SW        to core1 = captured sum_out0
//   out_valid     out  1         both sfp_out buses valid for row_idx
//   out_ready     in   1         consumer accepts row
//   ovf_err       out  1         sticky exchanged-sum overflow (see CONFIGURATION)
// BEHAVIOUR
//   - Reset: state IDLE, all outputs 0, row counter 0, capture regs 0. Reset mid-burst aborts with no done pulse.
//   - States (Moore, outputs decoded from registered state):
//     IDLE -> ACC -> ACC_W -> RD -> RD_W -> DIV1 -> DIV2 -> DRAIN -> OUT -> (ACC | DONE) -> IDLE.
//   - ACC: acc=1. RD: fifo_ext_rd0=fifo_ext_rd1=1. DIV1, DIV2: div=1. OUT: out_valid=1. DONE: done=1.
//   - All other outputs are 0 in every state not listed above.
//   - start accepted in IDLE only: start high at edge T0 puts ACC in cycle T0+1 and latches nrows.
//   - Row timeline relative to ACC at cycle 1: RD=3, DIV1=5, DIV2=6, OUT=8.
//   - Minimum row period is 8 cycles.
//   - Capture: on the edge ending RD, sum_in0<=sum_out1 and sum_in1<=sum_out0.
//   - sum_in0/sum_in1 are cleared to 0 on entering ACC and held from RD_W through OUT.
//   - OUT holds, with all other controls low, until out_ready=1.
//   - OUT with out_ready=1 and row_idx<nrows-1: row_idx++, go to ACC.
//   - OUT with out_ready=1 on the last row: go to DONE, then IDLE.
//   - out_ready is ignored outside OUT.
//   - nrows=0: start goes straight to DONE (done pulses at T0+2) with no acc/rd/div activity.
//   - start while busy is dropped and not queued.
//   - start in the DONE cycle is dropped.
//   - No arithmetic on the datapath; sums pass through unmodified at SW bits.
// CONFIGURATION
//   SFP_XCHG_OVF_CHK_EN defined:
//     - A 25-bit add of sum_out0+sum_out1 is evaluated in RD.
//     - If bit SW is set, ovf_err is set on the edge ending RD.
//     - ovf_err is sticky; it is cleared by reset or by an accepted start.
//   SFP_XCHG_OVF_CHK_EN undefined: no adder; ovf_err is tied 0. The port exists in both builds.
// TESTING
//   - Single row, nrows=1, sum_out0=24'h000120, sum_out1=24'h000064, out_ready=1:
//     acc@1, rd0/rd1@3, sum_in0=24'h64 and sum_in1=24'h120 from cycle 4, div@5-6, out_valid@8, done@9, busy low@10.
//   - Burst, nrows=8, out_ready=1: 8 out_valid pulses spaced 8 cycles apart, row_idx 0..7, one done pulse;
//     sum_in returns to 0 in each ACC.
//   - Backpressure: hold out_ready=0 for 5 cycles on row 2 -> OUT held 6 cycles with acc/div/rd low;
//     row 3 ACC follows the handshake cycle.
//   - Reset at DIV1 of row 3 -> next cycle: all outputs 0, busy=0, no done; new start with nrows=1 completes normally.
//   - nrows=0 start -> done pulses once with acc/div/rd never asserted.
//     start asserted while busy -> no effect on row count.
//   - With SFP_XCHG_OVF_CHK_EN: sum_out0=24'hFFFFFF, sum_out1=24'h000001 -> ovf_err=1 from cycle 4, persists, cleared by next start.
//     Without the macro: ovf_err stays 0.

Source files
------------

// File: rtl/sfp_sum_xchg_ctrl_if.sv
// Row sequencer <-> environment bundle: burst control, core strobes,
// partial-sum exchange buses and the row out_valid/out_ready handshake.
interface sfp_sum_xchg_ctrl_if #(
  parameter int bw      = 8,
  parameter int bw_psum = 2*bw+4,
  parameter int ROW_W   = 4
);
  localparam int SW = bw_psum + 4;

  logic             start;
  logic [ROW_W-1:0] nrows;
  logic             busy;
  logic             done;
  logic [ROW_W-1:0] row_idx;
  logic             acc;
  logic             div;
  logic             fifo_ext_rd0;
  logic             fifo_ext_rd1;
  logic [SW-1:0]    sum_out0;
  logic [SW-1:0]    sum_out1;
  logic [SW-1:0]    sum_in0;
  logic [SW-1:0]    sum_in1;
  logic             out_valid;
  logic             out_ready;
  logic             ovf_err;

  modport master (
    input  start, nrows,
    input  sum_out0, sum_out1,
    input  out_ready,
    output busy, done, row_idx,
    output acc, div,
    output fifo_ext_rd0, fifo_ext_rd1,
    output sum_in0, sum_in1,
    output out_valid, ovf_err
  );

  modport slave (
    output start, nrows,
    output sum_out0, sum_out1,
    output out_ready,
    input  busy, done, row_idx,
    input  acc, div,
    input  fifo_ext_rd0, fifo_ext_rd1,
    input  sum_in0, sum_in1,
    input  out_valid, ovf_err
  );
endinterface

// File: rtl/sfp_sum_xchg_ctrl.sv
// Row sequencer and partial-sum exchanger for two sfp_row cores.
// Ports: clk, reset (sync, active-high), bus (sfp_sum_xchg_ctrl_if.master):
//   start/nrows in, busy/done/row_idx out, acc/div/fifo_ext_rd0/1 to cores,
//   sum_out0/1 in, sum_in0/1 out (cross-coupled), out_valid/out_ready,
//   ovf_err. Optional overflow check enabled by SFP_XCHG_OVF_CHK_EN.
module sfp_sum_xchg_ctrl #(
  parameter int bw      = 8,
  parameter int bw_psum = 2*bw+4,
  parameter int ROW_W   = 4
) (
  input  logic clk,
  input  logic reset,
  sfp_sum_xchg_ctrl_if.master bus
);
  localparam int SW = bw_psum + 4;

  typedef enum logic [3:0] {
    S_IDLE, S_ACC, S_ACC_W, S_RD, S_RD_W,
    S_DIV1, S_DIV2, S_DRAIN, S_OUT, S_DONE
  } state_t;

  state_t           state;
  state_t           nxt;
  logic [ROW_W-1:0] nrows_q;
  logic [ROW_W-1:0] row_q;
  logic [SW-1:0]    in0_q;
  logic [SW-1:0]    in1_q;
  logic             busy_q;
  logic             done_q;
  logic             acc_q;
  logic             div_q;
  logic             rd_q;
  logic             ov_q;
  logic             last_row;
  logic             go;

  assign go = (state == S_IDLE) && bus.start;

  assign last_row =
    ((ROW_W+1)'(row_q) + (ROW_W+1)'(1))
    >= (ROW_W+1)'(nrows_q);

  // nrows=0 passes through ACC_W so done lands
  // one cycle later than a direct IDLE->DONE hop.
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:
        if (bus.start)
          nxt = (bus.nrows == '0) ? S_ACC_W : S_ACC;
      S_ACC:   nxt = S_ACC_W;
      S_ACC_W: nxt = (nrows_q == '0) ? S_DONE : S_RD;
      S_RD:    nxt = S_RD_W;
      S_RD_W:  nxt = S_DIV1;
      S_DIV1:  nxt = S_DIV2;
      S_DIV2:  nxt = S_DRAIN;
      S_DRAIN: nxt = S_OUT;
      S_OUT:
        if (bus.out_ready)
          nxt = last_row ? S_DONE : S_ACC;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so
  // they line up exactly with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      nrows_q <= '0;
      row_q   <= '0;
      in0_q   <= '0;
      in1_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      acc_q   <= 1'b0;
      div_q   <= 1'b0;
      rd_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state  <= nxt;
      busy_q <= (nxt != S_IDLE);
      done_q <= (nxt == S_DONE);
      acc_q  <= (nxt == S_ACC);
      rd_q   <= (nxt == S_RD);
      div_q  <= (nxt == S_DIV1) ||
                (nxt == S_DIV2);
      ov_q   <= (nxt == S_OUT);
      if (go) begin
        nrows_q <= bus.nrows;
        row_q   <= '0;
      end else if (state == S_OUT &&
                   bus.out_ready &&
                   !last_row) begin
        row_q <= row_q + ROW_W'(1);
      end
      if (nxt == S_ACC) begin
        in0_q <= '0;
        in1_q <= '0;
      end else if (state == S_RD) begin
        in0_q <= bus.sum_out1;
        in1_q <= bus.sum_out0;
      end
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.row_idx      = row_q;
  assign bus.acc          = acc_q;
  assign bus.div          = div_q;
  assign bus.fifo_ext_rd0 = rd_q;
  assign bus.fifo_ext_rd1 = rd_q;
  assign bus.sum_in0      = in0_q;
  assign bus.sum_in1      = in1_q;
  assign bus.out_valid    = ov_q;

`ifdef SFP_XCHG_OVF_CHK_EN
  logic [SW:0] ovf_sum;
  logic        ovf_q;

  assign ovf_sum = {1'b0, bus.sum_out0} +
                   {1'b0, bus.sum_out1};

  always_ff @(posedge clk) begin
    if (reset)
      ovf_q <= 1'b0;
    else if (go)
      ovf_q <= 1'b0;
    else if (state == S_RD && ovf_sum[SW])
      ovf_q <= 1'b1;
  end

  assign bus.ovf_err = ovf_q;
`else
  assign bus.ovf_err = 1'b0;
`endif
endmodule

// File: tb/tb_sfp_sum_xchg_ctrl.sv
// Directed bench for sfp_sum_xchg_ctrl with a row scoreboard:
// expected rows are queued at start and popped on each handshake.
module tb_sfp_sum_xchg_ctrl;
  localparam int SW    = 24;
  localparam int ROW_W = 4;

`ifdef SFP_XCHG_OVF_CHK_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  sfp_sum_xchg_ctrl_if bus ();

  sfp_sum_xchg_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;
  int acc_cnt = 0;
  int rd_cnt = 0;
  int div_cnt = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int hs_cnt = 0;
  int last_hs = -1;
  int acc_expect = -1;
  int hold_row = -1;
  int hold_left = 0;
  int hold_ov = 0;
  int tb_row = 0;
  bit chk_period = 1'b0;
  logic [SW-1:0] base0;
  logic [SW-1:0] base1;
  logic [63:0] sbq[$];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive_sums();
    bus.sum_out0 = base0 + SW'(tb_row);
    bus.sum_out1 = base1 + SW'(tb_row * 16);
  endtask

  task automatic push_rows(input int n);
    for (int r = 0; r < n; r++)
      sbq.push_back({12'h0, ROW_W'(r),
                     base1 + SW'(r * 16),
                     base0 + SW'(r)});
  endtask

  task automatic cyc();
    logic [63:0] e;
    @(posedge clk);
    #1;
    cyc_n++;
    if (bus.acc) begin
      acc_cnt++;
      chk("acc_sum_clear",
          {bus.sum_in0, bus.sum_in1}, 0);
    end
    if (cyc_n == acc_expect)
      chk("acc_after_hs", bus.acc, 1);
    if (bus.fifo_ext_rd0 || bus.fifo_ext_rd1) begin
      rd_cnt++;
      chk("rd_pair", bus.fifo_ext_rd0,
          bus.fifo_ext_rd1);
    end
    if (bus.div) div_cnt++;
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc_n;
    end
    if (bus.out_valid) begin
      chk("out_quiet", {bus.acc, bus.div,
          bus.fifo_ext_rd0, bus.fifo_ext_rd1}, 0);
      if (tb_row == hold_row) hold_ov++;
      if (bus.out_ready) begin
        chk("sb_has_entry", sbq.size() > 0, 1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          chk("row_data", {12'h0, bus.row_idx,
              bus.sum_in0, bus.sum_in1}, e);
        end
        if (chk_period && last_hs >= 0)
          chk("row_period", cyc_n - last_hs, 8);
        if (tb_row == hold_row)
          acc_expect = cyc_n + 1;
        last_hs = cyc_n;
        hs_cnt++;
        tb_row++;
        drive_sums();
      end else if (hold_left > 0) begin
        hold_left--;
      end
    end
    bus.out_ready =
      !(tb_row == hold_row && hold_left > 0);
  endtask

  task automatic start_burst(input int n);
    tb_row  = 0;
    last_hs = -1;
    cyc_n   = 0;
    drive_sums();
    push_rows(n);
    bus.nrows = ROW_W'(n);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic run_idle(input int max,
                          input int poke);
    for (int i = 0; i < max; i++) begin
      if (cyc_n == poke) begin
        bus.start = 1'b1;
        bus.nrows = ROW_W'(3);
      end else begin
        bus.start = 1'b0;
      end
      cyc();
      if (!bus.busy) break;
    end
    bus.start = 1'b0;
    chk("idle_reached", bus.busy, 0);
  endtask

  logic [6:0] tl [10];
  int a0, r0, d0, n0, h0;

  initial begin
    tl = '{7'b1100000, 7'b1000000, 7'b1011000,
           7'b1000000, 7'b1000100, 7'b1000100,
           7'b1000000, 7'b1000010, 7'b1000001,
           7'b0000000};
    reset = 1'b1;
    bus.start = 1'b0;
    bus.nrows = '0;
    bus.out_ready = 1'b1;
    base0 = '0;
    base1 = '0;
    drive_sums();
    cyc();
    cyc();
    chk("rst_ctrl", {bus.busy, bus.done, bus.acc,
        bus.div, bus.fifo_ext_rd0, bus.fifo_ext_rd1,
        bus.out_valid, bus.ovf_err}, 0);
    chk("rst_data", {bus.row_idx, bus.sum_in0,
        bus.sum_in1}, 0);
    reset = 1'b0;
    cyc();

    // single row timeline, start in DONE dropped
    base0 = 24'h000120;
    base1 = 24'h000064;
    start_burst(1);
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) cyc();
      chk($sformatf("tl_c%0d", c), {bus.busy,
          bus.acc, bus.fifo_ext_rd0,
          bus.fifo_ext_rd1, bus.div,
          bus.out_valid, bus.done}, tl[c-1]);
      if (c == 4)
        chk("xchg_c4", {bus.sum_in0, bus.sum_in1},
            {24'h000064, 24'h000120});
      chk("ovf_clean", bus.ovf_err, 0);
      bus.start = (c == 9);
      bus.nrows = ROW_W'(1);
    end
    bus.start = 1'b0;
    cyc();
    chk("drop_done_start", bus.busy, 0);
    chk("single_sb_empty", sbq.size(), 0);

    // 8-row burst with a start poke while busy
    base0 = 24'h001000;
    base1 = 24'h020000;
    a0 = acc_cnt; n0 = done_cnt; h0 = hs_cnt;
    chk_period = 1'b1;
    start_burst(8);
    run_idle(100, 20);
    chk_period = 1'b0;
    chk("burst_hs", hs_cnt - h0, 8);
    chk("burst_acc", acc_cnt - a0, 8);
    chk("burst_done", done_cnt - n0, 1);
    chk("burst_last_row", bus.row_idx, 7);
    chk("burst_sb_empty", sbq.size(), 0);
    cyc();
    chk("burst_poke_dropped", bus.busy, 0);

    // backpressure on row 2
    base0 = 24'h000003;
    base1 = 24'h000700;
    hold_row = 2; hold_left = 5; hold_ov = 0;
    h0 = hs_cnt;
    start_burst(4);
    run_idle(100, -1);
    chk("bp_out_cycles", hold_ov, 6);
    chk("bp_hs", hs_cnt - h0, 4);
    chk("bp_sb_empty", sbq.size(), 0);
    hold_row = -1; acc_expect = -1;
    bus.out_ready = 1'b1;

    // reset at DIV1 of row 3
    base0 = 24'h000055;
    base1 = 24'h000066;
    start_burst(5);
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (tb_row == 3 && bus.div) break;
    end
    chk("reach_div1_r3",
        (tb_row == 3) && bus.div, 1);
    n0 = done_cnt;
    reset = 1'b1;
    cyc();
    chk("midrst_ctrl", {bus.busy, bus.done,
        bus.acc, bus.div, bus.fifo_ext_rd0,
        bus.fifo_ext_rd1, bus.out_valid,
        bus.ovf_err}, 0);
    chk("midrst_data", {bus.row_idx, bus.sum_in0,
        bus.sum_in1}, 0);
    reset = 1'b0;
    sbq.delete();
    cyc(); cyc(); cyc();
    chk("midrst_no_done", done_cnt - n0, 0);
    h0 = hs_cnt;
    start_burst(1);
    run_idle(30, -1);
    chk("midrst_restart_hs", hs_cnt - h0, 1);
    chk("midrst_restart_done", done_cnt - n0, 1);

    // nrows = 0
    a0 = acc_cnt; r0 = rd_cnt; d0 = div_cnt;
    n0 = done_cnt; done_cyc = -1;
    start_burst(0);
    run_idle(20, -1);
    chk("zero_done_cyc", done_cyc, 2);
    chk("zero_done_cnt", done_cnt - n0, 1);
    chk("zero_quiet", {acc_cnt - a0, rd_cnt - r0,
        div_cnt - d0}, 0);

    // overflow sticky bit
    base0 = 24'hFFFFFF;
    base1 = 24'h000001;
    start_burst(1);
    cyc(); cyc();
    chk("ovf_c3", bus.ovf_err, 0);
    cyc();
    chk("ovf_c4", bus.ovf_err, OVF_ON);
    run_idle(30, -1);
    chk("ovf_sticky", bus.ovf_err, OVF_ON);
    base0 = 24'h000010;
    base1 = 24'h000020;
    start_burst(1);
    chk("ovf_clr_start", bus.ovf_err, 0);
    run_idle(30, -1);
    chk("ovf_stays_clr", bus.ovf_err, 0);
    chk("final_sb_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end
endmodule
